// File: rtl/serial_addsub_ctrl_if.sv
// Bundle between the bit-serial add/sub sequencer, its requester and the external ALU slice.
// The slave side is the sequencer; the master side is the requester plus the slice.
interface serial_addsub_ctrl_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             slice_A;
  logic             slice_B;
  logic             slice_Cin;
  logic             slice_sub;
  logic             slice_S;
  logic             slice_Cout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  modport master (
    output start, op_sub, a_in, b_in, slice_S, slice_Cout,
    input  slice_A, slice_B, slice_Cin, slice_sub,
    input  busy, done, result, negative, zero, overflow, carry_out
  );

  modport slave (
    input  start, op_sub, a_in, b_in, slice_S, slice_Cout,
    output slice_A, slice_B, slice_Cin, slice_sub,
    output busy, done, result, negative, zero, overflow, carry_out
  );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial sequencer driving one external addSub slice LSB first; collects the
// sum bits and produces result plus N/Z/V/C flags one cycle after the last bit.
module serial_addsub_ctrl #(
  parameter int WIDTH = 64
) (
  input logic                  clk,
  input logic                  reset,
  serial_addsub_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic             run;
  logic             last_bit;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] result_q;
  logic             op_q;
  logic             carry;
  logic             zacc;
  logic [CNT_W-1:0] cnt;
  logic             negative_q;
  logic             zero_q;
  logic             overflow_q;
  logic             carry_out_q;

  // Signed overflow: carry into the MSB differs from carry out of it.
  function automatic logic ovf_flag(input logic cin_msb, input logic cout_msb);
    return cin_msb ^ cout_msb;
  endfunction

  assign run      = (state_q == RUN);
  assign last_bit = run && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          accept  = 1'b1;
        end
      end
      RUN: begin
        if (cnt == LAST) state_d = DONE;
      end
      DONE: begin
        if (bus.start) begin
          state_d = RUN;
          accept  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Subtract seeds the carry with 1 so the slice's inverted B becomes two's complement.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh        <= '0;
      b_sh        <= '0;
      res_sh      <= '0;
      op_q        <= 1'b0;
      carry       <= 1'b0;
      zacc        <= 1'b0;
      cnt         <= '0;
      result_q    <= '0;
      negative_q  <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      carry_out_q <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.a_in;
      b_sh  <= bus.b_in;
      op_q  <= bus.op_sub;
      carry <= bus.op_sub;
      zacc  <= 1'b0;
      cnt   <= '0;
    end else if (run) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= {bus.slice_S, res_sh[WIDTH-1:1]};
      carry  <= bus.slice_Cout;
      zacc   <= zacc | bus.slice_S;
      cnt    <= cnt + 1'b1;
      if (last_bit) begin
        result_q    <= {bus.slice_S, res_sh[WIDTH-1:1]};
        negative_q  <= bus.slice_S;
        zero_q      <= ~(zacc | bus.slice_S);
        overflow_q  <= ovf_flag(carry, bus.slice_Cout);
        carry_out_q <= bus.slice_Cout;
      end
    end
  end

  assign bus.busy      = run;
  assign bus.done      = (state_q == DONE);
  assign bus.slice_A   = run & a_sh[0];
  assign bus.slice_B   = run & b_sh[0];
  assign bus.slice_Cin = run & carry;
  assign bus.slice_sub = run & op_q;
  assign bus.result    = result_q;
  assign bus.negative  = negative_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
  assign bus.carry_out = carry_out_q;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Bench for serial_addsub_ctrl: WIDTH=8 and WIDTH=64 instances, each with a real addSub
// slice, and a scoreboard of word-level A+/-B results with expected done cycles.
module tb_serial_addsub_ctrl;
  localparam int W8  = 8;
  localparam int W64 = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   bcnt8 = 0;
  int   bcnt64 = 0;

  typedef struct {
    logic [63:0] r;
    logic        n;
    logic        z;
    logic        v;
    logic        c;
    int          cyc;
  } exp_t;

  exp_t sb8[$];
  exp_t sb64[$];
  exp_t e8;
  exp_t e64;

  serial_addsub_ctrl_if #(.WIDTH(W8))  if8();
  serial_addsub_ctrl_if #(.WIDTH(W64)) if64();

  serial_addsub_ctrl #(.WIDTH(W8))  dut8  (.clk(clk), .reset(rst), .bus(if8.slave));
  serial_addsub_ctrl #(.WIDTH(W64)) dut64 (.clk(clk), .reset(rst), .bus(if64.slave));

  // addSub slices: B is inverted when subtracting, full adder otherwise
  logic bx8, bx64;
  assign bx8              = if8.slice_B ^ if8.slice_sub;
  assign if8.slice_S      = if8.slice_A ^ bx8 ^ if8.slice_Cin;
  assign if8.slice_Cout   = (if8.slice_A & bx8) | (if8.slice_Cin & (if8.slice_A ^ bx8));
  assign bx64             = if64.slice_B ^ if64.slice_sub;
  assign if64.slice_S     = if64.slice_A ^ bx64 ^ if64.slice_Cin;
  assign if64.slice_Cout  = (if64.slice_A & bx64) | (if64.slice_Cin & (if64.slice_A ^ bx64));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic sub,
                                 input int w, input int c);
    exp_t        e;
    logic [64:0] full;
    logic [63:0] mask;
    logic [63:0] am;
    logic [63:0] bi;
    mask   = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    am     = a & mask;
    bi     = sub ? (~b & mask) : (b & mask);
    full   = {1'b0, am} + {1'b0, bi} + {64'd0, sub};
    e.r    = full[63:0] & mask;
    e.c    = full[w];
    e.n    = e.r[w-1];
    e.z    = (e.r == 64'd0);
    e.v    = (am[w-1] == bi[w-1]) && (e.r[w-1] != am[w-1]);
    e.cyc  = c;
    return e;
  endfunction

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sub);
    int guard = 0;
    while (if8.busy === 1'b1 && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 1000) check("ready8", 64'(if8.busy), 64'd0);
    if8.start  = 1'b1;
    if8.op_sub = sub;
    if8.a_in   = a;
    if8.b_in   = b;
    sb8.push_back(model(64'(a), 64'(b), sub, W8, cyc + 1 + W8));
    @(posedge clk); #1;
  endtask

  task automatic issue64(input logic [63:0] a, input logic [63:0] b, input logic sub);
    int guard = 0;
    while (if64.busy === 1'b1 && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 1000) check("ready64", 64'(if64.busy), 64'd0);
    if64.start  = 1'b1;
    if64.op_sub = sub;
    if64.a_in   = a;
    if64.b_in   = b;
    sb64.push_back(model(a, b, sub, W64, cyc + 1 + W64));
    @(posedge clk); #1;
  endtask

  task automatic drain8();
    int guard = 0;
    while (sb8.size() != 0 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 500) begin
      check("drain8", 64'(sb8.size()), 64'd0);
      sb8.delete();
    end
  endtask

  task automatic drain64();
    int guard = 0;
    while (sb64.size() != 0 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 500) begin
      check("drain64", 64'(sb64.size()), 64'd0);
      sb64.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      bcnt8 = 0;
    end else begin
      if (if8.busy === 1'b1) bcnt8++;
      if (if8.done === 1'b1) begin
        if (sb8.size() == 0) begin
          check("unexp_done8", 64'(if8.done), 64'd0);
        end else begin
          e8 = sb8.pop_front();
          check("result8", 64'(if8.result), e8.r);
          check("nzvc8", 64'({if8.negative, if8.zero, if8.overflow, if8.carry_out}),
                64'({e8.n, e8.z, e8.v, e8.c}));
          check("latency8", 64'(cyc), 64'(e8.cyc));
          check("busy_len8", 64'(bcnt8), 64'(W8));
          check("slice_idle8", 64'({if8.slice_A, if8.slice_B, if8.slice_Cin, if8.slice_sub}), 64'd0);
        end
        bcnt8 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      bcnt64 = 0;
    end else begin
      if (if64.busy === 1'b1) bcnt64++;
      if (if64.done === 1'b1) begin
        if (sb64.size() == 0) begin
          check("unexp_done64", 64'(if64.done), 64'd0);
        end else begin
          e64 = sb64.pop_front();
          check("result64", if64.result, e64.r);
          check("nzvc64", 64'({if64.negative, if64.zero, if64.overflow, if64.carry_out}),
                64'({e64.n, e64.z, e64.v, e64.c}));
          check("latency64", 64'(cyc), 64'(e64.cyc));
          check("busy_len64", 64'(bcnt64), 64'(W64));
        end
        bcnt64 = 0;
      end
    end
  end

  initial begin
    if8.start   = 1'b0;
    if8.op_sub  = 1'b0;
    if8.a_in    = '0;
    if8.b_in    = '0;
    if64.start  = 1'b0;
    if64.op_sub = 1'b0;
    if64.a_in   = '0;
    if64.b_in   = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_busy", 64'(if8.busy), 64'd0);
    check("rst_done", 64'(if8.done), 64'd0);
    check("rst_result", 64'(if8.result), 64'd0);
    check("rst_flags", 64'({if8.negative, if8.zero, if8.overflow, if8.carry_out}), 64'd0);
    check("rst_slice", 64'({if8.slice_A, if8.slice_B, if8.slice_Cin, if8.slice_sub}), 64'd0);

    // plain add
    issue8(8'd5, 8'd3, 1'b0);
    if8.start = 1'b0;
    drain8();
    check("t1_result", 64'(if8.result), 64'd8);
    check("t1_flags", 64'({if8.negative, if8.zero, if8.overflow, if8.carry_out}), 64'b0000);

    // subtract with borrow, then equal operands
    issue8(8'd3, 8'd5, 1'b1);
    if8.start = 1'b0;
    drain8();
    check("t2_result", 64'(if8.result), 64'hFE);
    check("t2_flags", 64'({if8.negative, if8.zero, if8.overflow, if8.carry_out}), 64'b1000);
    issue8(8'd5, 8'd5, 1'b1);
    if8.start = 1'b0;
    drain8();
    check("t2b_flags", 64'({if8.negative, if8.zero, if8.overflow, if8.carry_out}), 64'b0101);

    // signed overflow, then unsigned wrap
    issue8(8'h7F, 8'h01, 1'b0);
    if8.start = 1'b0;
    drain8();
    check("t3_result", 64'(if8.result), 64'h80);
    check("t3_flags", 64'({if8.negative, if8.zero, if8.overflow, if8.carry_out}), 64'b1010);
    issue8(8'hFF, 8'h01, 1'b0);
    if8.start = 1'b0;
    drain8();
    check("t3b_flags", 64'({if8.negative, if8.zero, if8.overflow, if8.carry_out}), 64'b0101);

    // start pulses during RUN cycles 2-5 must not disturb the running op
    issue8(8'h21, 8'h13, 1'b0);
    if8.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if8.start  = 1'b1;
      if8.op_sub = 1'b1;
      if8.a_in   = 8'hA0 + 8'(i);
      if8.b_in   = 8'h55;
    end
    @(posedge clk); #1;
    if8.start = 1'b0;
    drain8();
    check("t4_result", 64'(if8.result), 64'h34);

    // reset on RUN cycle 4 aborts without a done pulse
    issue8(8'h40, 8'h02, 1'b0);
    if8.start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_busy", 64'(if8.busy), 64'd0);
    check("t5_done", 64'(if8.done), 64'd0);
    check("t5_result", 64'(if8.result), 64'd0);
    check("t5_flags", 64'({if8.negative, if8.zero, if8.overflow, if8.carry_out}), 64'd0);
    sb8.delete();
    repeat (12) begin
      @(posedge clk); #1;
    end
    issue8(8'h12, 8'h34, 1'b1);
    if8.start = 1'b0;
    drain8();

    // start held through DONE gives back-to-back ops
    for (int i = 0; i < 6; i++)
      issue8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    if8.start = 1'b0;
    drain8();

    // WIDTH=64 corners then random back-to-back ops
    issue64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    issue64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    issue64(64'd0, 64'd1, 1'b1);
    issue64(64'h8000_0000_0000_0000, 64'd1, 1'b1);
    for (int i = 0; i < 100; i++)
      issue64({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
    if64.start = 1'b0;
    drain64();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
